reg_select_read_port: RTL and testbench
=======================================

Name: reg_select_read_port

Overview:
- Register-select and read-port stage wrapped around the general register file.
- Upstream side: decodes instruction-register fields into the file's one-hot write enables.
- Downstream side: picks one register out of the packed register stream and delivers it through a one-entry ready/valid output buffer to the datapath bus.
- Adds write-to-read bypass, the R0-as-zero base-address rule, and a sticky select-conflict flag.

Parameters:
- BITS, 32, register width.
- REGISTERS, 16, register count; fixed at 16 because the IR fields are 4 bits wide.
- SELW, 4, register index width.

Ports:
- clk  input  1  system clock, rising edge.
- clr  input  1  asynchronous, active-low reset.
- ir  input  BITS  instruction register. Ra = ir[26:23], Rb = ir[22:19], Rc = ir[18:15].
- gra, grb, grc  input  1 each  field select.
- rin  input  1  write strobe.
- rout  input  1  read qualifier.
- baout  input  1  base-address read qualifier.
- busMuxOut  input  BITS  bus value being written this cycle.
- registerStream  input  BITS*REGISTERS  packed register contents; register i occupies [(i+1)*BITS-1 : i*BITS].
- loadEnable  output  REGISTERS  one-hot write enable to the register file.
- rd_req  input  1  read request.
- rd_ready  output  1  read request can be accepted this cycle.
- rd_valid  output  1  rd_data/rd_index hold a result.
- rd_accept  input  1  downstream consumes the result.
- rd_data  output  BITS  read result.
- rd_index  output  SELW  index the result came from.
- sel_err  output  1  sticky select-conflict flag.

Behaviour:
- Clocking and reset: one clock domain (clk). clr is asynchronous and active-low.
- While clr = 0:
  - rd_valid = 0, rd_data = 0, rd_index = 0, sel_err = 0.
  - loadEnable is forced to 0.
  - A reset in the middle of a transfer discards the held result; there is no replay.
- Index select (combinational):
  - idx = Ra if gra; else Rb if grb; else Rc if grc; else 0.
  - Priority is gra > grb > grc.
- Write decode (combinational, zero latency):
  - loadEnable = one-hot(idx) when rin = 1 and at least one of gra/grb/grc = 1; otherwise all zeros.
  - Never more than one bit is set.
- Handshake:
  - rd_ready = !rd_valid || rd_accept (single-entry pipeline buffer).
  - A read is accepted when rd_req && rd_ready && (rout || baout).
  - rd_req while both rout and baout are 0 is ignored; no state changes.
- Read capture, on the clock edge after acceptance:
  - rd_valid <= 1 and rd_index <= idx. Latency is 1 cycle.
  - rd_data value, in this order:
    - (a) baout = 1 and idx = 0 -> 0.
    - (b) Else, if loadEnable[idx] is asserted in the accepting cycle -> busMuxOut (bypass).
    - (c) Else -> registerStream slice idx.
- Hold and turnover:
  - rd_valid && !rd_accept: rd_data, rd_index and rd_valid hold, even if the registerStream contents change.
  - rd_accept with no new accepted read: rd_valid <= 0 next cycle; rd_data keeps its last value.
  - rd_accept together with a new accepted read in the same cycle: back-to-back transfer, so rd_valid stays 1 with the new data.
  - One transfer per cycle is sustainable.
- Conflict flag:
  - sel_err <= 1 on any edge where (rin || rout || baout) and two or more of gra/grb/grc are asserted.
  - Once set it stays set until clr; otherwise it holds.
  - The operation still proceeds using the priority index.
- Arithmetic: none. Slices are indexed purely through idx*BITS; there is no wrap or overflow case.

Test Plan:
- Reset release:
  - Stimulus: clr low with all inputs toggling.
  - Required: every output 0, loadEnable = 0. After clr goes high and inputs are idle, rd_ready = 1.
- Basic read:
  - Stimulus: R5 = 0xDEADBEEF in the stream; ir[22:19] = 5, grb = 1, rout = 1, rd_req = 1 for one cycle.
  - Required: next cycle rd_valid = 1, rd_data = 0xDEADBEEF, rd_index = 5.
- Backpressure:
  - Stimulus: hold rd_accept = 0 for 3 cycles while the stream value of R5 changes to 0x1; keep rd_req high.
  - Required: rd_ready = 0; rd_data stays 0xDEADBEEF.
  - Then rd_accept = 1 with rd_req high: next cycle rd_data = 0x1 and rd_valid stays 1.
- Bypass:
  - Stimulus: gra = 1, Ra = 7, rin = 1, rout = 1, rd_req = 1, busMuxOut = 0x12345678, stream R7 = 0.
  - Required: loadEnable = 0x0080 in the same cycle; next cycle rd_data = 0x12345678.
- Base address:
  - Stimulus: Ra = 0, gra = 1, baout = 1, stream R0 = 0xFFFF_FFFF.
  - Required: rd_data = 0.
  - Repeat with rout instead of baout: rd_data = 0xFFFF_FFFF.
- Conflict and priority:
  - Stimulus: gra = grc = 1, Ra = 2, Rc = 9, rin = 1.
  - Required: loadEnable = 0x0004; sel_err = 1 from the next cycle, still 1 after 10 idle cycles; cleared only by a clr pulse.

Source files
------------

// File: rtl/reg_select_read_port_if.sv
// Read-port handshake bundle: one-entry ready/valid buffer toward the datapath bus.
// A read transfers when rd_req && rd_ready; a result is consumed when rd_valid && rd_accept.
interface reg_select_read_port_if #(
    parameter int BITS = 32,
    parameter int SELW = 4
);
    logic            rd_req;
    logic            rd_ready;
    logic            rd_valid;
    logic            rd_accept;
    logic [BITS-1:0] rd_data;
    logic [SELW-1:0] rd_index;

    modport slave (
        input  rd_req,
        input  rd_accept,
        output rd_ready,
        output rd_valid,
        output rd_data,
        output rd_index
    );

    modport master (
        output rd_req,
        output rd_accept,
        input  rd_ready,
        input  rd_valid,
        input  rd_data,
        input  rd_index
    );
endinterface

// File: rtl/reg_select_read_port.sv
// Register-select / read-port stage: IR field decode to one-hot write enables, plus a
// buffered read port with write-to-read bypass, R0-as-zero base rule and sticky conflict flag.
module reg_select_read_port #(
    parameter int BITS      = 32,
    parameter int REGISTERS = 16,
    parameter int SELW      = 4
) (
    input  logic                      clk,
    input  logic                      clr,
    input  logic [BITS-1:0]           ir,
    input  logic                      gra,
    input  logic                      grb,
    input  logic                      grc,
    input  logic                      rin,
    input  logic                      rout,
    input  logic                      baout,
    input  logic [BITS-1:0]           busMuxOut,
    input  logic [BITS*REGISTERS-1:0] registerStream,
    output logic [REGISTERS-1:0]      loadEnable,
    output logic                      sel_err,
    reg_select_read_port_if.slave     rd
);
    logic [SELW-1:0] idx;
    logic            any_sel;
    logic            multi_sel;
    logic            rd_fire;
    logic [BITS-1:0] read_value;

    logic            rd_valid_q, rd_valid_d;
    logic [BITS-1:0] rd_data_q,  rd_data_d;
    logic [SELW-1:0] rd_index_q, rd_index_d;
    logic            sel_err_q,  sel_err_d;

    // Only the three 4-bit register fields of the IR are meaningful here.
    logic unused_ir_bits;
    assign unused_ir_bits = ^{ir[BITS-1:27], ir[14:0]};

    always_comb begin
        idx = '0;
        if (gra)      idx = ir[26:23];
        else if (grb) idx = ir[22:19];
        else if (grc) idx = ir[18:15];
    end

    assign any_sel   = gra | grb | grc;
    assign multi_sel = (gra & grb) | (gra & grc) | (grb & grc);

    // Gated by clr so the register file cannot be written while this stage is in reset.
    always_comb begin
        loadEnable = '0;
        if (clr && rin && any_sel) loadEnable[idx] = 1'b1;
    end

    assign rd.rd_ready = !rd_valid_q || rd.rd_accept;
    assign rd_fire     = rd.rd_req && rd.rd_ready && (rout || baout);

    // Base-address zero rule outranks the bypass; bypass outranks the stored value.
    always_comb begin
        read_value = registerStream[int'(idx)*BITS +: BITS];
        if (baout && (idx == '0))  read_value = '0;
        else if (loadEnable[idx])  read_value = busMuxOut;
    end

    always_comb begin
        rd_valid_d = rd_valid_q;
        rd_data_d  = rd_data_q;
        rd_index_d = rd_index_q;
        sel_err_d  = sel_err_q;
        if (rd_fire) begin
            rd_valid_d = 1'b1;
            rd_data_d  = read_value;
            rd_index_d = idx;
        end else if (rd.rd_accept) begin
            rd_valid_d = 1'b0;
        end
        if ((rin || rout || baout) && multi_sel) sel_err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            rd_index_q <= '0;
            sel_err_q  <= 1'b0;
        end else begin
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            rd_index_q <= rd_index_d;
            sel_err_q  <= sel_err_d;
        end
    end

    assign rd.rd_valid = rd_valid_q;
    assign rd.rd_data  = rd_data_q;
    assign rd.rd_index = rd_index_q;
    assign sel_err     = sel_err_q;
endmodule

// File: tb/tb_reg_select_read_port.sv
// Directed bench for reg_select_read_port: reset, read, backpressure, bypass, base rule, conflict.
module tb_reg_select_read_port;
  localparam int BITS = 32;
  localparam int REGS = 16;
  localparam int SELW = 4;

  logic                 clk;
  logic                 clr;
  logic [BITS-1:0]      ir;
  logic                 gra, grb, grc, rin, rout, baout;
  logic [BITS-1:0]      busMuxOut;
  logic [BITS*REGS-1:0] registerStream;
  logic [REGS-1:0]      loadEnable;
  logic                 sel_err;

  int checks;
  int errors;

  reg_select_read_port_if #(.BITS(BITS), .SELW(SELW)) rd_if ();

  reg_select_read_port #(.BITS(BITS), .REGISTERS(REGS), .SELW(SELW)) dut (
    .clk            (clk),
    .clr            (clr),
    .ir             (ir),
    .gra            (gra),
    .grb            (grb),
    .grc            (grc),
    .rin            (rin),
    .rout           (rout),
    .baout          (baout),
    .busMuxOut      (busMuxOut),
    .registerStream (registerStream),
    .loadEnable     (loadEnable),
    .sel_err        (sel_err),
    .rd             (rd_if.slave)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_reg(input int i, input logic [BITS-1:0] v);
    registerStream[i*BITS +: BITS] = v;
  endtask

  task automatic idle_inputs();
    ir = '0; gra = 0; grb = 0; grc = 0; rin = 0; rout = 0; baout = 0;
    busMuxOut = '0; rd_if.rd_req = 0; rd_if.rd_accept = 0;
  endtask

  task automatic test_reset();
    clr = 1'b0;
    idle_inputs();
    registerStream = '0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      ir = $urandom; gra = 1; grb = 1; grc = $urandom_range(0, 1);
      rin = 1; rout = 1; baout = $urandom_range(0, 1);
      busMuxOut = $urandom; rd_if.rd_req = 1; rd_if.rd_accept = $urandom_range(0, 1);
      registerStream = {REGS{32'hA5A5_5A5A}};
      #1;
      checks++;
      if (loadEnable !== 16'h0000) begin
        errors++; $display("FAIL reset_load_enable got %h want 0000", loadEnable);
      end
      @(posedge clk); #1;
      checks++;
      if (rd_if.rd_valid !== 1'b0 || rd_if.rd_data !== 32'h0 || rd_if.rd_index !== 4'h0 || sel_err !== 1'b0) begin
        errors++;
        $display("FAIL reset_outputs got valid=%b data=%h index=%h err=%b want all 0",
                 rd_if.rd_valid, rd_if.rd_data, rd_if.rd_index, sel_err);
      end
    end
    @(negedge clk);
    idle_inputs();
    registerStream = '0;
    clr = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (rd_if.rd_ready !== 1'b1 || rd_if.rd_valid !== 1'b0 || sel_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_release got ready=%b valid=%b err=%b want 1 0 0",
               rd_if.rd_ready, rd_if.rd_valid, sel_err);
    end
  endtask

  task automatic test_ignored_request();
    @(negedge clk);
    idle_inputs();
    set_reg(3, 32'h0000_0033);
    ir = 32'(3) << 19; grb = 1; rd_if.rd_req = 1;
    @(posedge clk); #1;
    checks++;
    if (rd_if.rd_valid !== 1'b0 || rd_if.rd_data !== 32'h0) begin
      errors++;
      $display("FAIL ignored_request got valid=%b data=%h want 0 00000000", rd_if.rd_valid, rd_if.rd_data);
    end
    @(negedge clk);
    idle_inputs();
    rin = 1;
    #1;
    checks++;
    if (loadEnable !== 16'h0000) begin
      errors++; $display("FAIL rin_no_select got %h want 0000", loadEnable);
    end
  endtask

  task automatic test_basic_read();
    @(negedge clk);
    idle_inputs();
    set_reg(5, 32'hDEAD_BEEF);
    ir = 32'(5) << 19; grb = 1; rout = 1; rd_if.rd_req = 1;
    @(posedge clk); #1;
    checks++;
    if (rd_if.rd_valid !== 1'b1 || rd_if.rd_data !== 32'hDEAD_BEEF || rd_if.rd_index !== 4'd5) begin
      errors++;
      $display("FAIL basic_read got valid=%b data=%h index=%0d want 1 deadbeef 5",
               rd_if.rd_valid, rd_if.rd_data, rd_if.rd_index);
    end
  endtask

  task automatic test_backpressure();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      set_reg(5, 32'h0000_0001);
      rd_if.rd_req = 1; rd_if.rd_accept = 0;
      #1;
      checks++;
      if (rd_if.rd_ready !== 1'b0) begin
        errors++; $display("FAIL bp_ready cycle %0d got %b want 0", c, rd_if.rd_ready);
      end
      @(posedge clk); #1;
      checks++;
      if (rd_if.rd_valid !== 1'b1 || rd_if.rd_data !== 32'hDEAD_BEEF) begin
        errors++;
        $display("FAIL bp_hold cycle %0d got valid=%b data=%h want 1 deadbeef", c, rd_if.rd_valid, rd_if.rd_data);
      end
    end
    @(negedge clk);
    rd_if.rd_accept = 1; rd_if.rd_req = 1;
    #1;
    checks++;
    if (rd_if.rd_ready !== 1'b1) begin
      errors++; $display("FAIL bp_accept_ready got %b want 1", rd_if.rd_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (rd_if.rd_valid !== 1'b1 || rd_if.rd_data !== 32'h0000_0001 || rd_if.rd_index !== 4'd5) begin
      errors++;
      $display("FAIL bp_back_to_back got valid=%b data=%h index=%0d want 1 00000001 5",
               rd_if.rd_valid, rd_if.rd_data, rd_if.rd_index);
    end
    @(negedge clk);
    rd_if.rd_req = 0; rd_if.rd_accept = 1;
    @(posedge clk); #1;
    checks++;
    if (rd_if.rd_valid !== 1'b0 || rd_if.rd_data !== 32'h0000_0001) begin
      errors++;
      $display("FAIL drain got valid=%b data=%h want 0 00000001", rd_if.rd_valid, rd_if.rd_data);
    end
  endtask

  task automatic test_bypass();
    @(negedge clk);
    idle_inputs();
    set_reg(7, 32'h0);
    ir = 32'(7) << 23; gra = 1; rin = 1; rout = 1; rd_if.rd_req = 1;
    busMuxOut = 32'h1234_5678;
    #1;
    checks++;
    if (loadEnable !== 16'h0080) begin
      errors++; $display("FAIL bypass_load_enable got %h want 0080", loadEnable);
    end
    @(posedge clk); #1;
    checks++;
    if (rd_if.rd_valid !== 1'b1 || rd_if.rd_data !== 32'h1234_5678 || rd_if.rd_index !== 4'd7) begin
      errors++;
      $display("FAIL bypass_data got valid=%b data=%h index=%0d want 1 12345678 7",
               rd_if.rd_valid, rd_if.rd_data, rd_if.rd_index);
    end
    @(negedge clk);
    idle_inputs();
    rd_if.rd_accept = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_base_addr();
    @(negedge clk);
    idle_inputs();
    set_reg(0, 32'hFFFF_FFFF);
    ir = '0; gra = 1; baout = 1; rd_if.rd_req = 1;
    @(posedge clk); #1;
    checks++;
    if (rd_if.rd_valid !== 1'b1 || rd_if.rd_data !== 32'h0 || rd_if.rd_index !== 4'd0) begin
      errors++;
      $display("FAIL base_addr_zero got valid=%b data=%h want 1 00000000", rd_if.rd_valid, rd_if.rd_data);
    end
    @(negedge clk);
    baout = 0; rout = 1; rd_if.rd_req = 1; rd_if.rd_accept = 1;
    @(posedge clk); #1;
    checks++;
    if (rd_if.rd_valid !== 1'b1 || rd_if.rd_data !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL rout_r0 got valid=%b data=%h want 1 ffffffff", rd_if.rd_valid, rd_if.rd_data);
    end
    @(negedge clk);
    idle_inputs();
    rd_if.rd_accept = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_conflict();
    @(negedge clk);
    idle_inputs();
    ir = (32'(2) << 23) | (32'(9) << 15); gra = 1; grc = 1; rin = 1;
    #1;
    checks++;
    if (loadEnable !== 16'h0004 || sel_err !== 1'b0) begin
      errors++;
      $display("FAIL conflict_priority got le=%h err=%b want 0004 0", loadEnable, sel_err);
    end
    @(posedge clk); #1;
    checks++;
    if (sel_err !== 1'b1) begin
      errors++; $display("FAIL conflict_set got %b want 1", sel_err);
    end
    @(negedge clk);
    idle_inputs();
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (sel_err !== 1'b1) begin
      errors++; $display("FAIL conflict_sticky got %b want 1", sel_err);
    end
    @(negedge clk);
    clr = 1'b0;
    #1;
    checks++;
    if (sel_err !== 1'b0) begin
      errors++; $display("FAIL conflict_clear got %b want 0", sel_err);
    end
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (sel_err !== 1'b0) begin
      errors++; $display("FAIL conflict_after_clr got %b want 0", sel_err);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_ignored_request();
    test_basic_read();
    test_backpressure();
    test_bypass();
    test_base_addr();
    test_conflict();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
